// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a single-clock FIFO and its producer/consumer.
// The master side drives requests and write data; the slave side (the FIFO) returns data and flags.
interface sync_fifo_param_if #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  flush;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  w_en;
    logic                  r_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush,
        output data_in,
        output w_en,
        output r_en,
        input  data_out,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  flush,
        input  data_in,
        input  w_en,
        input  r_en,
        output data_out,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost flags, sticky error flags,
// synchronous flush and optional first-word-fall-through read mode.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_param_if.slave  bus
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [CNT_W-1:0]      wptr_q;
    logic [CNT_W-1:0]      rptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      wptr_nxt;
    logic [CNT_W-1:0]      rptr_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    always_comb begin
        rd_acc    = bus.r_en && !empty_q;
        wr_acc    = bus.w_en && (!full_q || rd_acc);
        wptr_nxt  = wptr_q + {{ADDR_W{1'b0}}, wr_acc};
        rptr_nxt  = rptr_q + {{ADDR_W{1'b0}}, rd_acc};
        count_nxt = wptr_nxt - rptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !bus.flush) begin
            mem[wptr_q[ADDR_W-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (bus.flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_nxt;
            rptr_q  <= rptr_nxt;
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_C);
            ae_q    <= (count_nxt <= AE_C);
            ovf_q   <= ovf_q | (bus.w_en && full_q && !rd_acc);
            unf_q   <= unf_q | (bus.r_en && empty_q);
        end
    end

    // FWFT: the head after this edge is either the word being written (FIFO was
    // draining to that slot) or an already stored word at the advanced read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (!bus.flush) begin
            if (FWFT != 0) begin
                if (wr_acc && (wptr_q == rptr_nxt)) begin
                    dout_q <= bus.data_in;
                end else if (count_nxt != '0) begin
                    dout_q <= mem[rptr_nxt[ADDR_W-1:0]];
                end
            end else if (rd_acc) begin
                dout_q <= mem[rptr_q[ADDR_W-1:0]];
            end
        end
    end

    assign bus.data_out     = dout_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: standard-mode instance checked against a
// queue scoreboard every cycle, FWFT instance checked with a short directed sequence.
module tb_sync_fifo_param;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus_s ();
    sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus_f ();

    sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0))
        u_std (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));
    sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(bus_f.slave));

    int           n_checks = 0;
    int           n_errors = 0;
    int           m_cnt;
    logic         m_ovf;
    logic         m_unf;
    logic [W-1:0] m_dout;
    logic [W-1:0] sb[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_count"}, 64'(bus_s.count), 64'(m_cnt));
        check_val({tag, "_full"}, 64'(bus_s.full), 64'(m_cnt == D));
        check_val({tag, "_empty"}, 64'(bus_s.empty), 64'(m_cnt == 0));
        check_val({tag, "_afull"}, 64'(bus_s.almost_full), 64'(m_cnt >= AF));
        check_val({tag, "_aempty"}, 64'(bus_s.almost_empty), 64'(m_cnt <= AE));
        check_val({tag, "_ovf"}, 64'(bus_s.overflow), 64'(m_ovf));
        check_val({tag, "_unf"}, 64'(bus_s.underflow), 64'(m_unf));
        check_val({tag, "_dout"}, 64'(bus_s.data_out), 64'(m_dout));
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
        sb.delete();
    endtask

    task automatic step(input logic w, input logic r, input logic [W-1:0] d, input string tag);
        bit rd_acc;
        bit wr_acc;
        bus_s.w_en    = w;
        bus_s.r_en    = r;
        bus_s.data_in = d;
        rd_acc = r && (m_cnt > 0);
        wr_acc = w && ((m_cnt < D) || rd_acc);
        if (w && (m_cnt == D) && !rd_acc) m_ovf = 1'b1;
        if (r && (m_cnt == 0)) m_unf = 1'b1;
        if (rd_acc) m_dout = sb.pop_front();
        if (wr_acc) sb.push_back(d);
        m_cnt = m_cnt + int'(wr_acc) - int'(rd_acc);
        @(posedge clk);
        #1;
        bus_s.w_en = 1'b0;
        bus_s.r_en = 1'b0;
        check_state(tag);
    endtask

    task automatic flush_step(input string tag);
        bus_s.flush   = 1'b1;
        bus_s.w_en    = 1'b1;
        bus_s.r_en    = 1'b1;
        bus_s.data_in = 32'hDEAD_BEEF;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        bus_s.flush = 1'b0;
        bus_s.w_en  = 1'b0;
        bus_s.r_en  = 1'b0;
        check_state(tag);
    endtask

    task automatic fstep(input logic w, input logic r, input logic [W-1:0] d);
        bus_f.w_en    = w;
        bus_f.r_en    = r;
        bus_f.data_in = d;
        @(posedge clk);
        #1;
        bus_f.w_en = 1'b0;
        bus_f.r_en = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus_s.flush   = 1'b0;
        bus_s.w_en    = 1'b0;
        bus_s.r_en    = 1'b0;
        bus_s.data_in = '0;
        bus_f.flush   = 1'b0;
        bus_f.w_en    = 1'b0;
        bus_f.r_en    = 1'b0;
        bus_f.data_in = '0;
        model_reset();
        #12;
        check_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fill to full, then one rejected write
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(i), "t1_wr");
        step(1'b1, 1'b0, 32'h99, "t1_ovf");

        // drain in order, then one read on empty
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0, "t2_rd");
        step(1'b0, 1'b1, '0, "t2_unf");

        // streaming through a full FIFO across pointer wrap
        flush_step("t3_flush");
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(32'h100 + i), "t3_fill");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, W'(32'h200 + i), "t3_wr_rd");
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0, "t3_drain");

        // simultaneous read/write on empty: write only, underflow flagged
        flush_step("t4_flush");
        step(1'b1, 1'b1, 32'hA5, "t4_simul");
        step(1'b0, 1'b1, '0, "t4_rd");

        // FWFT instance
        fstep(1'b1, 1'b0, 32'h3C);
        check_val("fwft_wr_empty", 64'(bus_f.empty), 64'd0);
        check_val("fwft_wr_dout", 64'(bus_f.data_out), 64'h3C);
        check_val("fwft_wr_count", 64'(bus_f.count), 64'd1);
        fstep(1'b0, 1'b1, '0);
        check_val("fwft_pop_empty", 64'(bus_f.empty), 64'd1);
        check_val("fwft_pop_dout", 64'(bus_f.data_out), 64'h3C);
        fstep(1'b1, 1'b0, 32'h11);
        fstep(1'b1, 1'b0, 32'h22);
        check_val("fwft_two_dout", 64'(bus_f.data_out), 64'h11);
        check_val("fwft_two_count", 64'(bus_f.count), 64'd2);
        fstep(1'b0, 1'b1, '0);
        check_val("fwft_next_dout", 64'(bus_f.data_out), 64'h22);
        fstep(1'b0, 1'b1, '0);
        check_val("fwft_last_empty", 64'(bus_f.empty), 64'd1);
        check_val("fwft_last_dout", 64'(bus_f.data_out), 64'h22);
        check_val("fwft_unf_pre", 64'(bus_f.underflow), 64'd0);
        fstep(1'b0, 1'b1, '0);
        check_val("fwft_unf", 64'(bus_f.underflow), 64'd1);

        // count=9 with overflow set, then flush with a write pending
        flush_step("t6_flush0");
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(32'h300 + i), "t6_fill");
        step(1'b1, 1'b0, 32'h3FF, "t6_ovf");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0, "t6_rd");
        check_val("t6_count9", 64'(bus_s.count), 64'd9);
        flush_step("t6_flush");
        step(1'b0, 1'b1, '0, "t6_post_flush");

        // async reset in the middle of a write burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(32'h400 + i), "t6_burst");
        bus_s.w_en    = 1'b1;
        bus_s.data_in = 32'h4FF;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("t6_async_rst");
        check_val("t6_rst_fwft_empty", 64'(bus_f.empty), 64'd1);
        check_val("t6_rst_fwft_dout", 64'(bus_f.data_out), 64'd0);
        bus_s.w_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("t6_after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
